pipe_hazard_ctrl: RTL

//  Hazard and sequencing controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipe_pkg.sv | 46 ++++
 rtl/pipe_hazard_ctrl_if.sv | 34 +++
 rtl/rv_inst_class.sv | 40 ++++
 rtl/pipe_hazard_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared opcodes, enums and shadow-stage record for the hazard controller
package pipe_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       regwen;
    logic       is_load;
    logic       is_mem;
  } stage_info_t;

  localparam stage_info_t STAGE_BUBBLE = '0;

  // MEM wins over WB; a load in MEM has no data yet, so it never forwards from MEM.
  function automatic fwd_sel_e fwd_pick(stage_info_t mem_s, stage_info_t wb_s, logic [4:0] rs);
    if (mem_s.valid && mem_s.regwen && (mem_s.rd != 5'd0) && !mem_s.is_load && (mem_s.rd == rs))
      return FWD_MEM;
    if (wb_s.valid && wb_s.regwen && (wb_s.rd != 5'd0) && (wb_s.rd == rs))
      return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline-side signal bundle of the hazard controller
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      id_inst;
  logic             id_valid;
  logic             ex_pcsel;
  logic             dmem_ready;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_en;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             dmem_req;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_inst, id_valid, ex_pcsel, dmem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
    input  fwd_a, fwd_b, dmem_req, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_inst, id_valid, ex_pcsel, dmem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
    output fwd_a, fwd_b, dmem_req, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/rv_inst_class.sv
// rtl/rv_inst_class.sv - classifies the ID instruction into register use and write-back info
module rv_inst_class
  import pipe_pkg::*;
(
  input  logic [31:0] inst,
  input  logic        valid,
  output stage_info_t info,
  output logic        uses_rs1,
  output logic        uses_rs2
);

  logic regwen;
  logic unused_bits;

  // funct fields do not affect hazards or forwarding
  assign unused_bits = ^{inst[31:25], inst[14:12]};

  // Opcode decode; unused source fields are zeroed so they can never match a producer.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    regwen   = 1'b0;
    case (inst[6:0])
      OPC_R:                                   begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; regwen = 1'b1; end
      OPC_BRANCH, OPC_STORE:                   begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OPC_IMM, OPC_LOAD, OPC_JALR:             begin uses_rs1 = 1'b1; regwen = 1'b1; end
      OPC_LUI, OPC_AUIPC, OPC_JAL:             regwen = 1'b1;
      default:                                 ;
    endcase
    info         = STAGE_BUBBLE;
    info.valid   = valid;
    info.rd      = regwen   ? inst[11:7]  : 5'd0;
    info.rs1     = uses_rs1 ? inst[19:15] : 5'd0;
    info.rs2     = uses_rs2 ? inst[24:20] : 5'd0;
    info.regwen  = regwen;
    info.is_load = (inst[6:0] == OPC_LOAD);
    info.is_mem  = (inst[6:0] == OPC_LOAD) || (inst[6:0] == OPC_STORE);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use, redirect and memory-wait controller with EX forwarding
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  stage_info_t id_s, ex_s, mem_s, wb_s;
  logic        uses_rs1, uses_rs2;

  mem_state_e        state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              mem_err_q;
  logic [CNT_W-1:0]  stall_q, flush_q;

  logic dmem_req, mem_stall, redirect, hazard, load_use;
  logic unused_wb;

  rv_inst_class u_cls (
    .inst     (bus.id_inst),
    .valid    (bus.id_valid),
    .info     (id_s),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  // WB only sources forwarding; its operand/memory fields are carried along for completeness
  assign unused_wb = ^{wb_s.rs1, wb_s.rs2, wb_s.is_load, wb_s.is_mem};

  assign dmem_req  = mem_s.valid && mem_s.is_mem;
  assign mem_stall = dmem_req && !bus.dmem_ready;
  assign redirect  = !mem_stall && ex_s.valid && bus.ex_pcsel;
  assign hazard    = id_s.valid && ex_s.valid && ex_s.is_load && (ex_s.rd != 5'd0) &&
                     ((uses_rs1 && (id_s.rs1 == ex_s.rd)) || (uses_rs2 && (id_s.rs2 == ex_s.rd)));
  // a redirect makes the ID instruction wrong-path, so its hazard is moot
  assign load_use  = !mem_stall && !redirect && hazard;

  // Shadow scoreboard: frozen by a memory stall, bubble inserted on redirect or load-use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_s  <= STAGE_BUBBLE;
      mem_s <= STAGE_BUBBLE;
      wb_s  <= STAGE_BUBBLE;
    end else if (!mem_stall) begin
      wb_s  <= mem_s;
      mem_s <= ex_s;
      ex_s  <= (redirect || load_use) ? STAGE_BUBBLE : id_s;
    end
  end

  // Memory FSM state register with wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= M_IDLE;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if ((state_nxt == M_WAIT) && (wait_cnt_nxt >= WAIT_MAX))
        mem_err_q <= 1'b1;
    end
  end

  // Memory FSM next state; the counter saturates at the timeout while waiting continues.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      M_IDLE: begin
        if (mem_stall) begin
          state_nxt    = M_WAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end
      end
      M_WAIT: begin
        if (!mem_stall) begin
          state_nxt    = M_IDLE;
          wait_cnt_nxt = '0;
        end else if (wait_cnt != WAIT_MAX) begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      default: begin
        state_nxt    = M_IDLE;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // Pipeline enables/flushes by priority: memory stall, then redirect, then load-use.
  always_comb begin
    bus.pc_en      = 1'b1;
    bus.ifid_en    = 1'b1;
    bus.ifid_flush = 1'b0;
    bus.idex_en    = 1'b1;
    bus.idex_flush = 1'b0;
    bus.exmem_en   = 1'b1;
    bus.memwb_en   = 1'b1;
    if (mem_stall) begin
      bus.pc_en    = 1'b0;
      bus.ifid_en  = 1'b0;
      bus.idex_en  = 1'b0;
      bus.exmem_en = 1'b0;
      bus.memwb_en = 1'b0;
    end else if (redirect) begin
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
    end else if (load_use) begin
      bus.pc_en      = 1'b0;
      bus.ifid_en    = 1'b0;
      bus.idex_flush = 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if ((mem_stall || load_use) && (stall_q != '1))
        stall_q <= stall_q + CNT_W'(1);
      if (redirect && (flush_q != '1))
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.fwd_a     = fwd_pick(mem_s, wb_s, ex_s.rs1);
  assign bus.fwd_b     = fwd_pick(mem_s, wb_s, ex_s.rs2);
  assign bus.dmem_req  = dmem_req;
  assign bus.mem_err   = mem_err_q;
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;

endmodule
